// File: rtl/brv32p_pkg.sv
// -----------------------------------------------------------------------------
// brv32p_pkg
// Shared types for the brv32p SoC fabric. This slice carries the AXI response
// encoding and the state set of the AXI4-Lite responder, plus a helper that
// maps a peripheral error bit onto an AXI response code.
// -----------------------------------------------------------------------------
package brv32p_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_BRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RCAP  = 3'd4,
    ST_RRESP = 3'd5
  } axil_rsp_state_e;

  function automatic axi_resp_t err_to_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/brv32p_axil_responder_if.sv
// -----------------------------------------------------------------------------
// brv32p_axil_responder_if
// AXI4-Lite channel bundle between an interconnect master and a peripheral
// responder. Five channels: AW (awvalid/awready/awaddr), W (wvalid/wready/
// wdata/wstrb), B (bvalid/bready/bresp), AR (arvalid/arready/araddr) and
// R (rvalid/rready/rdata/rresp).
//   master modport : drives the request channels and the B/R ready signals
//   slave  modport : drives the request readies and the B/R response channels
// -----------------------------------------------------------------------------
interface brv32p_axil_responder_if
  import brv32p_pkg::*;
#(
  parameter int ADDR_W = 12
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  axi_resp_t         bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  axi_resp_t         rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/brv32p_hold_reg.sv
// -----------------------------------------------------------------------------
// brv32p_hold_reg
// One-entry holding register for a valid/ready channel. The owner computes
// set = valid & ready (ready being !full) and clr when the entry is consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   set        : capture d and mark full
//   clr        : release the entry
//   d          : payload to capture
//   full       : entry occupied (channel ready is its inverse)
//   q          : held payload
// -----------------------------------------------------------------------------
module brv32p_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);
  logic         full_d, full_q;
  logic [W-1:0] data_d, data_q;

  // set only fires while empty and clr only while full, so they never collide.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    full_d = full_q;
    data_d = data_q;
    if (set) begin
      full_d = 1'b1;
      data_d = d;
    end else if (clr) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      // NOTE: the payload is reset as well; it is a single word, and a known value keeps reg_* outputs clean after reset.
      data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign q    = data_q;
endmodule

// File: rtl/brv32p_axil_responder.sv
// -----------------------------------------------------------------------------
// brv32p_axil_responder
// AXI4-Lite subordinate that turns each AXI transaction into a single-cycle
// register-port access for a peripheral bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   s          : AXI4-Lite slave port (AW/W/B/AR/R)
//   reg_wr_en  : one-cycle write strobe
//   reg_rd_en  : one-cycle read strobe
//   reg_addr   : word index (byte address bits [ADDR_W-1:2])
//   reg_wdata  : write data, reg_wstrb : byte strobes
//   reg_rdata  : read data, valid the cycle after reg_rd_en
//   reg_err    : peripheral error, sampled with reg_wr_en or with reg_rdata
// -----------------------------------------------------------------------------
module brv32p_axil_responder
  import brv32p_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  brv32p_axil_responder_if.slave  s,
  output logic                    reg_wr_en,
  output logic                    reg_rd_en,
  output logic [ADDR_W-3:0]       reg_addr,
  output logic [31:0]             reg_wdata,
  output logic [3:0]              reg_wstrb,
  input  logic [31:0]             reg_rdata,
  input  logic                    reg_err
);
  localparam int IW = ADDR_W - 2;

  // ---- request holds -------------------------------------------------------
  logic          aw_full, w_full, ar_full;
  logic          aw_clr, w_clr, ar_clr;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [35:0]   w_hold;

  brv32p_hold_reg #(.W(IW)) u_aw_hold (
    .clk(clk), .rst_n(rst_n), .set(s.awvalid & ~aw_full), .clr(aw_clr),
    .d(s.awaddr[ADDR_W-1:2]), .full(aw_full), .q(aw_idx)
  );

  brv32p_hold_reg #(.W(36)) u_w_hold (
    .clk(clk), .rst_n(rst_n), .set(s.wvalid & ~w_full), .clr(w_clr),
    .d({s.wstrb, s.wdata}), .full(w_full), .q(w_hold)
  );

  brv32p_hold_reg #(.W(IW)) u_ar_hold (
    .clk(clk), .rst_n(rst_n), .set(s.arvalid & ~ar_full), .clr(ar_clr),
    .d(s.araddr[ADDR_W-1:2]), .full(ar_full), .q(ar_idx)
  );

  assign s.awready = ~aw_full;
  assign s.wready  = ~w_full;
  assign s.arready = ~ar_full;

  // Byte-offset bits carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s.awaddr[1:0], s.araddr[1:0]};

  // ---- FSM, arbiter, issue and response registers --------------------------
  axil_rsp_state_e state_d, state_q;
  logic            last_was_write_d, last_was_write_q;
  logic [IW-1:0]   iss_addr_d, iss_addr_q;
  logic [31:0]     iss_wdata_d, iss_wdata_q;
  logic [3:0]      iss_wstrb_d, iss_wstrb_q;
  axi_resp_t       bresp_d, bresp_q;
  axi_resp_t       rresp_d, rresp_q;
  logic [31:0]     rdata_d, rdata_q;

  logic wr_ok, rd_ok, pick_wr;
  assign wr_ok = aw_full & w_full;
  assign rd_ok = ar_full;
  // Write wins unless the previous contended decision already went to a write.
  assign pick_wr = wr_ok & (~rd_ok | ~last_was_write_q);

  always_comb begin
    state_d          = state_q;
    last_was_write_d = last_was_write_q;
    iss_addr_d       = iss_addr_q;
    iss_wdata_d      = iss_wdata_q;
    iss_wstrb_d      = iss_wstrb_q;
    bresp_d          = bresp_q;
    rresp_d          = rresp_q;
    rdata_d          = rdata_q;
    aw_clr           = 1'b0;
    w_clr            = 1'b0;
    ar_clr           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The priority flag only moves when both directions were contending,
        // so an uncontested access never steals the other side's next turn.
        if (pick_wr) begin
          state_d     = ST_WR;
          aw_clr      = 1'b1;
          w_clr       = 1'b1;
          iss_addr_d  = aw_idx;
          iss_wdata_d = w_hold[31:0];
          iss_wstrb_d = w_hold[35:32];
          if (rd_ok) last_was_write_d = 1'b1;
        end else if (rd_ok) begin
          state_d    = ST_RD;
          ar_clr     = 1'b1;
          iss_addr_d = ar_idx;
          if (wr_ok) last_was_write_d = 1'b0;
        end
      end
      ST_WR: begin
        // No strobes means no register access, hence nothing can fail.
        bresp_d = (iss_wstrb_q != 4'b0000) ? err_to_resp(reg_err) : RESP_OKAY;
        state_d = ST_BRESP;
      end
      ST_BRESP: if (s.bready) state_d = ST_IDLE;
      ST_RD:    state_d = ST_RCAP;
      ST_RCAP: begin
        rdata_d = reg_rdata;
        rresp_d = err_to_resp(reg_err);
        state_d = ST_RRESP;
      end
      ST_RRESP: if (s.rready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      last_was_write_q <= 1'b0;
      iss_addr_q       <= '0;
      iss_wdata_q      <= '0;
      iss_wstrb_q      <= '0;
      bresp_q          <= RESP_OKAY;
      rresp_q          <= RESP_OKAY;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      last_was_write_q <= last_was_write_d;
      iss_addr_q       <= iss_addr_d;
      iss_wdata_q      <= iss_wdata_d;
      iss_wstrb_q      <= iss_wstrb_d;
      bresp_q          <= bresp_d;
      rresp_q          <= rresp_d;
      rdata_q          <= rdata_d;
    end
  end

  // Strobes decode straight from the state flop, so an asynchronous reset
  // kills them immediately and no partial access can follow.
  assign reg_wr_en = (state_q == ST_WR) && (iss_wstrb_q != 4'b0000);
  assign reg_rd_en = (state_q == ST_RD);
  assign reg_addr  = iss_addr_q;
  assign reg_wdata = iss_wdata_q;
  assign reg_wstrb = iss_wstrb_q;

  assign s.bvalid = (state_q == ST_BRESP);
  assign s.bresp  = bresp_q;
  assign s.rvalid = (state_q == ST_RRESP);
  assign s.rdata  = rdata_q;
  assign s.rresp  = rresp_q;
endmodule

// File: tb/tb_brv32p_axil_responder.sv
// -----------------------------------------------------------------------------
// tb_brv32p_axil_responder
// Directed self-checking bench for brv32p_axil_responder. Inputs change 1 ns
// after a rising edge; outputs are compared at that same point, well clear of
// the next edge. Strobe pulses are counted on falling edges.
// -----------------------------------------------------------------------------
module tb_brv32p_axil_responder;
  import brv32p_pkg::*;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst_n;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-3:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_wstrb;
  logic [31:0]       reg_rdata;
  logic              reg_err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;

  brv32p_axil_responder_if #(.ADDR_W(ADDR_W)) axi ();

  brv32p_axil_responder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (axi.slave),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb),
    .reg_rdata (reg_rdata),
    .reg_err   (reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) wr_cnt++;
    if (reg_rd_en === 1'b1) rd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valids();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.arvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (axi.awready !== 1'b1) begin failures++; $display("FAIL reset_awready got=%b exp=1", axi.awready); end
    checks++; if (axi.wready !== 1'b1) begin failures++; $display("FAIL reset_wready got=%b exp=1", axi.wready); end
    checks++; if (axi.arready !== 1'b1) begin failures++; $display("FAIL reset_arready got=%b exp=1", axi.arready); end
    checks++; if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) begin failures++; $display("FAIL reset_valids got b=%b r=%b exp=0/0", axi.bvalid, axi.rvalid); end
    checks++; if (axi.bresp !== 2'b00 || axi.rresp !== 2'b00 || axi.rdata !== 32'h0) begin failures++; $display("FAIL reset_resp got bresp=%b rresp=%b rdata=%h exp=00/00/0", axi.bresp, axi.rresp, axi.rdata); end
    checks++; if (reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0) begin failures++; $display("FAIL reset_strobes got wr=%b rd=%b exp=0/0", reg_wr_en, reg_rd_en); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int w0 = wr_cnt;
    axi.awvalid = 1'b1; axi.awaddr = 12'h008;
    axi.wvalid  = 1'b1; axi.wdata  = 32'hDEADBEEF; axi.wstrb = 4'hF;
    tick();  // handshake edge k
    drop_valids();
    checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL sw_wr_early got=%b exp=0", reg_wr_en); end
    tick();  // k+1
    checks++; if (reg_wr_en !== 1'b1) begin failures++; $display("FAIL sw_wr_en got=%b exp=1", reg_wr_en); end
    checks++; if (reg_addr !== 10'd2 || reg_wdata !== 32'hDEADBEEF || reg_wstrb !== 4'hF) begin failures++; $display("FAIL sw_payload got addr=%0d data=%h strb=%h exp=2/deadbeef/f", reg_addr, reg_wdata, reg_wstrb); end
    checks++; if (axi.bvalid !== 1'b0) begin failures++; $display("FAIL sw_bvalid_early got=%b exp=0", axi.bvalid); end
    tick();  // k+2
    checks++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin failures++; $display("FAIL sw_bresp got bvalid=%b bresp=%b exp=1/00", axi.bvalid, axi.bresp); end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++; if (axi.bvalid !== 1'b0) begin failures++; $display("FAIL sw_bvalid_drop got=%b exp=0", axi.bvalid); end
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL sw_pulses got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_w_before_aw();
    int w0 = wr_cnt;
    reg_err = 1'b1;
    axi.wvalid = 1'b1; axi.wdata = 32'hA5A50001; axi.wstrb = 4'b0011;
    tick();
    drop_valids();
    checks++; if (axi.wready !== 1'b0 || axi.awready !== 1'b1) begin failures++; $display("FAIL wa_hold_ready got w=%b aw=%b exp=0/1", axi.wready, axi.awready); end
    tick();
    tick();
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL wa_no_early_write got=%0d exp=%0d", wr_cnt, w0); end
    axi.awvalid = 1'b1; axi.awaddr = 12'h010;
    tick();  // k
    drop_valids();
    checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL wa_wr_early got=%b exp=0", reg_wr_en); end
    tick();  // k+1
    checks++; if (reg_wr_en !== 1'b1 || reg_addr !== 10'd4 || reg_wdata !== 32'hA5A50001 || reg_wstrb !== 4'b0011) begin failures++; $display("FAIL wa_access got wr=%b addr=%0d data=%h strb=%b exp=1/4/a5a50001/0011", reg_wr_en, reg_addr, reg_wdata, reg_wstrb); end
    tick();  // k+2
    reg_err = 1'b0;
    checks++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b10) begin failures++; $display("FAIL wa_bresp got bvalid=%b bresp=%b exp=1/10", axi.bvalid, axi.bresp); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b10 || axi.awready !== 1'b1 || axi.wready !== 1'b1) begin failures++; $display("FAIL wa_bhold[%0d] got bvalid=%b bresp=%b awr=%b wr=%b exp=1/10/1/1", i, axi.bvalid, axi.bresp, axi.awready, axi.wready); end
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++; if (axi.bvalid !== 1'b0) begin failures++; $display("FAIL wa_bvalid_drop got=%b exp=0", axi.bvalid); end
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL wa_pulses got=%0d exp=1", wr_cnt - w0); end
  endtask

  task automatic test_read_err();
    int r0 = rd_cnt;
    reg_rdata = 32'h12345678; reg_err = 1'b1;
    axi.arvalid = 1'b1; axi.araddr = 12'h00F;  // low bits ignored -> index 3
    tick();  // k
    drop_valids();
    checks++; if (reg_rd_en !== 1'b0 || axi.rvalid !== 1'b0) begin failures++; $display("FAIL rd_early got rd=%b rvalid=%b exp=0/0", reg_rd_en, axi.rvalid); end
    tick();  // k+1
    checks++; if (reg_rd_en !== 1'b1 || reg_addr !== 10'd3) begin failures++; $display("FAIL rd_strobe got rd=%b addr=%0d exp=1/3", reg_rd_en, reg_addr); end
    tick();  // k+2
    checks++; if (reg_rd_en !== 1'b0 || axi.rvalid !== 1'b0) begin failures++; $display("FAIL rd_capture_cycle got rd=%b rvalid=%b exp=0/0", reg_rd_en, axi.rvalid); end
    tick();  // k+3
    checks++; if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h12345678 || axi.rresp !== 2'b10) begin failures++; $display("FAIL rd_resp got rvalid=%b rdata=%h rresp=%b exp=1/12345678/10", axi.rvalid, axi.rdata, axi.rresp); end
    reg_rdata = 32'h0; reg_err = 1'b0;
    tick();
    tick();
    checks++; if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h12345678 || axi.rresp !== 2'b10) begin failures++; $display("FAIL rd_hold got rvalid=%b rdata=%h rresp=%b exp=1/12345678/10", axi.rvalid, axi.rdata, axi.rresp); end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    checks++; if (axi.rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_drop got=%b exp=0", axi.rvalid); end
    checks++; if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL rd_pulses got=%0d exp=1", rd_cnt - r0); end
  endtask

  task automatic test_arbitration();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    reg_err = 1'b0; reg_rdata = 32'hCAFE0001;
    axi.awvalid = 1'b1; axi.awaddr = 12'h020;
    axi.wvalid  = 1'b1; axi.wdata  = 32'h11111111; axi.wstrb = 4'hF;
    axi.arvalid = 1'b1; axi.araddr = 12'h030;
    tick();  // k
    drop_valids();
    tick();  // k+1: write first
    checks++; if (reg_wr_en !== 1'b1 || reg_rd_en !== 1'b0 || reg_addr !== 10'd8) begin failures++; $display("FAIL arb1_write_first got wr=%b rd=%b addr=%0d exp=1/0/8", reg_wr_en, reg_rd_en, reg_addr); end
    tick();  // k+2
    checks++; if (axi.bvalid !== 1'b1) begin failures++; $display("FAIL arb1_bvalid got=%b exp=1", axi.bvalid); end
    axi.bready = 1'b1;
    tick();  // k+3: idle
    axi.bready = 1'b0;
    tick();  // k+4: queued read
    checks++; if (reg_rd_en !== 1'b1 || reg_addr !== 10'd12) begin failures++; $display("FAIL arb1_read_second got rd=%b addr=%0d exp=1/12", reg_rd_en, reg_addr); end
    axi.rready = 1'b1;
    tick();
    tick();  // k+6
    checks++; if (axi.rvalid !== 1'b1 || axi.rdata !== 32'hCAFE0001) begin failures++; $display("FAIL arb1_rresp got rvalid=%b rdata=%h exp=1/cafe0001", axi.rvalid, axi.rdata); end
    tick();  // k+7: idle
    axi.rready = 1'b0;
    axi.awvalid = 1'b1; axi.awaddr = 12'h040;
    axi.wvalid  = 1'b1; axi.wdata  = 32'h22222222; axi.wstrb = 4'hF;
    axi.arvalid = 1'b1; axi.araddr = 12'h050;
    tick();  // k'
    drop_valids();
    tick();  // k'+1: read first this time
    checks++; if (reg_rd_en !== 1'b1 || reg_wr_en !== 1'b0 || reg_addr !== 10'd20) begin failures++; $display("FAIL arb2_read_first got rd=%b wr=%b addr=%0d exp=1/0/20", reg_rd_en, reg_wr_en, reg_addr); end
    tick();
    tick();  // k'+3
    checks++; if (axi.rvalid !== 1'b1) begin failures++; $display("FAIL arb2_rvalid got=%b exp=1", axi.rvalid); end
    axi.rready = 1'b1;
    tick();  // k'+4: idle
    axi.rready = 1'b0;
    tick();  // k'+5: queued write
    checks++; if (reg_wr_en !== 1'b1 || reg_addr !== 10'd16 || reg_wdata !== 32'h22222222) begin failures++; $display("FAIL arb2_write_second got wr=%b addr=%0d data=%h exp=1/16/22222222", reg_wr_en, reg_addr, reg_wdata); end
    tick();
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++; if (axi.bvalid !== 1'b0) begin failures++; $display("FAIL arb2_bdone got=%b exp=0", axi.bvalid); end
  endtask

  task automatic test_zero_strb();
    int w0 = wr_cnt;
    reg_err = 1'b1;
    axi.awvalid = 1'b1; axi.awaddr = 12'h004;
    axi.wvalid  = 1'b1; axi.wdata  = 32'hFFFFFFFF; axi.wstrb = 4'b0000;
    tick();  // k
    drop_valids();
    tick();  // k+1
    checks++; if (reg_wr_en !== 1'b0) begin failures++; $display("FAIL zs_no_strobe got=%b exp=0", reg_wr_en); end
    tick();  // k+2
    checks++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin failures++; $display("FAIL zs_bresp got bvalid=%b bresp=%b exp=1/00", axi.bvalid, axi.bresp); end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    reg_err = 1'b0;
    checks++; if (wr_cnt !== w0) begin failures++; $display("FAIL zs_pulses got=%0d exp=%0d", wr_cnt - w0, 0); end
  endtask

  task automatic test_reset_mid();
    int r0 = rd_cnt;
    reg_rdata = 32'h0BADF00D; reg_err = 1'b1;
    axi.arvalid = 1'b1; axi.araddr = 12'h000;
    tick();  // k
    drop_valids();
    tick();  // k+1 RD
    tick();  // k+2 RCAP
    rst_n = 1'b0;
    #1;
    checks++; if (axi.rvalid !== 1'b0 || axi.rdata !== 32'h0 || axi.rresp !== 2'b00) begin failures++; $display("FAIL rm_async got rvalid=%b rdata=%h rresp=%b exp=0/0/00", axi.rvalid, axi.rdata, axi.rresp); end
    checks++; if (axi.awready !== 1'b1 || axi.wready !== 1'b1 || axi.arready !== 1'b1) begin failures++; $display("FAIL rm_readies got aw=%b w=%b ar=%b exp=1/1/1", axi.awready, axi.wready, axi.arready); end
    tick();
    tick();
    checks++; if (axi.rvalid !== 1'b0 || rd_cnt - r0 !== 1 || reg_wr_en !== 1'b0) begin failures++; $display("FAIL rm_quiet got rvalid=%b rd_pulses=%0d wr=%b exp=0/1/0", axi.rvalid, rd_cnt - r0, reg_wr_en); end
    rst_n = 1'b1;
    reg_err = 1'b0;
    tick();
    axi.awvalid = 1'b1; axi.awaddr = 12'h0FC;
    axi.wvalid  = 1'b1; axi.wdata  = 32'h00000005; axi.wstrb = 4'hF;
    tick();  // k
    drop_valids();
    tick();  // k+1: idle FSM issues promptly
    checks++; if (reg_wr_en !== 1'b1 || reg_addr !== 10'd63) begin failures++; $display("FAIL rm_after_write got wr=%b addr=%0d exp=1/63", reg_wr_en, reg_addr); end
    tick();
    checks++; if (axi.bvalid !== 1'b1 || axi.rvalid !== 1'b0) begin failures++; $display("FAIL rm_after_resp got bvalid=%b rvalid=%b exp=1/0", axi.bvalid, axi.rvalid); end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    axi.awvalid = 1'b0; axi.awaddr = '0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0;
    axi.rready  = 1'b0;
    reg_rdata   = '0;
    reg_err     = 1'b0;

    test_reset();
    test_single_write();
    test_w_before_aw();
    test_read_err();
    test_arbitration();
    test_zero_strb();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
